// File: rtl/fft_frame_loader_if.sv
// Sample-stream / FFT-frame bus of the FFT front-end loader.
// master drives samples and fft_done; slave (the loader) drives the frame and status.
interface fft_frame_loader_if #(
  parameter int ADC_W = 12
);
  logic             sample_valid;
  logic [ADC_W-1:0] sample_in;
  logic             fft_done;
  logic [15:0]      t0, t1, t2, t3, t4, t5, t6, t7;
  logic [15:0]      t8, t9, t10, t11, t12, t13, t14, t15;
  logic             new_t;
  logic             busy;
  logic             overrun;

  modport master (
    output sample_valid, sample_in, fft_done,
    input  t0, t1, t2, t3, t4, t5, t6, t7,
    input  t8, t9, t10, t11, t12, t13, t14, t15,
    input  new_t, busy, overrun
  );

  modport slave (
    input  sample_valid, sample_in, fft_done,
    output t0, t1, t2, t3, t4, t5, t6, t7,
    output t8, t9, t10, t11, t12, t13, t14, t15,
    output new_t, busy, overrun
  );
endinterface

// File: rtl/fft_frame_loader.sv
// Packs a free-running ADC stream into 16-sample signed frames (-512..511) and
// launches the FFT; one frame may wait in a pending bank while the FFT is busy.
module fft_frame_loader #(
  parameter int ADC_W         = 12,
  parameter bit OFFSET_BINARY = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  fft_frame_loader_if.slave  bus
);

  localparam logic [0:0] STATE_IDLE = 1'b0;
  localparam logic [0:0] STATE_BUSY = 1'b1;

  localparam int                    SHIFT  = ADC_W - 10;
  localparam logic signed [ADC_W:0] HALF   = (ADC_W+1)'(1) << (ADC_W-1);
  localparam logic signed [ADC_W:0] SAT_HI = (ADC_W+1)'(511);
  localparam logic signed [ADC_W:0] SAT_LO = -(ADC_W+1)'(512);

  logic signed [ADC_W:0] s_raw;
  logic signed [ADC_W:0] s_shift;
  logic signed [9:0]     sat;
  logic [15:0]           conv;

  logic [3:0]  idx_q, idx_d;
  logic        pend_q, pend_d;
  logic [0:0]  state_q, state_d;
  logic        new_t_q, new_t_d;
  logic        overrun_q, overrun_d;
  logic [15:0] cap_q [16];
  logic [15:0] cap_d [16];
  logic [15:0] pend_bank_q [16];
  logic [15:0] pend_bank_d [16];
  logic [15:0] t_q [16];
  logic [15:0] t_d [16];
  logic        frame_done;
  logic        launch;

  // Re-centre offset-binary codes, drop the extra LSBs, then saturate to 10 bits.
  always_comb begin
    if (OFFSET_BINARY) s_raw = $signed({1'b0, bus.sample_in}) - HALF;
    else               s_raw = $signed({bus.sample_in[ADC_W-1], bus.sample_in});
    s_shift = s_raw >>> SHIFT;
    if (s_shift > SAT_HI)      sat = 10'sh1FF;
    else if (s_shift < SAT_LO) sat = 10'sh200;
    else                       sat = s_shift[9:0];
    conv = {{6{sat[9]}}, sat};
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    cap_d       = cap_q;
    pend_bank_d = pend_bank_q;
    t_d         = t_q;
    idx_d       = idx_q;
    pend_d      = pend_q;
    state_d     = state_q;
    overrun_d   = overrun_q;
    new_t_d     = 1'b0;
    frame_done  = bus.sample_valid && (idx_q == 4'd15);
    launch      = (state_q == STATE_IDLE) && pend_q;

    if (bus.sample_valid) begin
      cap_d[idx_q] = conv;
      idx_d        = idx_q + 4'd1;
    end

    case (state_q)
      STATE_IDLE: begin
        if (pend_q) begin
          t_d     = pend_bank_q;
          new_t_d = 1'b1;
          pend_d  = 1'b0;
          state_d = STATE_BUSY;
        end
      end
      STATE_BUSY: begin
        // A done seen during the launch cycle belongs to the previous frame.
        if (!new_t_q && bus.fft_done) state_d = STATE_IDLE;
      end
      default: state_d = STATE_IDLE;
    endcase

    // A launch in this same edge frees the pending bank for the new frame.
    if (frame_done) begin
      if (!pend_q || launch) begin
        pend_bank_d = cap_d;
        pend_d      = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= '0;
      pend_q    <= 1'b0;
      state_q   <= STATE_IDLE;
      new_t_q   <= 1'b0;
      overrun_q <= 1'b0;
      // NOTE: the sample banks are cleared too, so t0..t15 never expose pre-reset data.
      for (int i = 0; i < 16; i++) begin
        cap_q[i]       <= '0;
        pend_bank_q[i] <= '0;
        t_q[i]         <= '0;
      end
    end else begin
      idx_q       <= idx_d;
      pend_q      <= pend_d;
      state_q     <= state_d;
      new_t_q     <= new_t_d;
      overrun_q   <= overrun_d;
      cap_q       <= cap_d;
      pend_bank_q <= pend_bank_d;
      t_q         <= t_d;
    end
  end

  assign bus.t0      = t_q[0];
  assign bus.t1      = t_q[1];
  assign bus.t2      = t_q[2];
  assign bus.t3      = t_q[3];
  assign bus.t4      = t_q[4];
  assign bus.t5      = t_q[5];
  assign bus.t6      = t_q[6];
  assign bus.t7      = t_q[7];
  assign bus.t8      = t_q[8];
  assign bus.t9      = t_q[9];
  assign bus.t10     = t_q[10];
  assign bus.t11     = t_q[11];
  assign bus.t12     = t_q[12];
  assign bus.t13     = t_q[13];
  assign bus.t14     = t_q[14];
  assign bus.t15     = t_q[15];
  assign bus.new_t   = new_t_q;
  assign bus.busy    = (state_q == STATE_BUSY);
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_fft_frame_loader.sv
// Scoreboard bench for fft_frame_loader: stimulus pushes expected frames, monitors
// pop and compare on every new_t; directed checks cover timing, reset and overrun.
module tb_fft_frame_loader;

  typedef logic [15:0][11:0] vec_t;
  typedef logic [15:0][15:0] frame_t;
  typedef struct packed {
    frame_t      t;
    logic [31:0] cyc;
    logic        chk_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   last_exp_cyc = 0;
  exp_t q1[$];
  exp_t q2[$];

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  fft_frame_loader_if #(.ADC_W(12)) bus ();
  fft_frame_loader_if #(.ADC_W(12)) bus2 ();

  fft_frame_loader #(.ADC_W(12), .OFFSET_BINARY(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  fft_frame_loader #(.ADC_W(12), .OFFSET_BINARY(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
    end
  endtask

  // Reference conversion in plain integer arithmetic.
  function automatic logic [15:0] model(input logic [11:0] x, input logic ob);
    int s;
    if (ob) s = int'(x) - 2048;
    else    s = int'($signed(x));
    s = s >>> 2;
    if (s > 511)       s = 511;
    else if (s < -512) s = -512;
    return 16'(s);
  endfunction

  function automatic vec_t gen(input int seed);
    vec_t v;
    for (int i = 0; i < 16; i++) v[i] = 12'(seed * 97 + i * 251);
    return v;
  endfunction

  task automatic cmp_frame(input string tag, input exp_t e, input frame_t act);
    for (int i = 0; i < 16; i++)
      check($sformatf("%s t%0d", tag, i), 32'(act[i]), 32'(e.t[i]));
    if (e.chk_cyc) check({tag, " launch_cycle"}, 32'(cyc), e.cyc);
  endtask

  initial forever begin
    @(negedge clk);
    if (rst_n && bus.new_t) begin
      if (q1.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL launch_unexpected: new_t=1 at cycle %0d, expected no launch", cyc);
      end else begin
        cmp_frame("frame", q1.pop_front(),
                  {bus.t15, bus.t14, bus.t13, bus.t12, bus.t11, bus.t10, bus.t9, bus.t8,
                   bus.t7, bus.t6, bus.t5, bus.t4, bus.t3, bus.t2, bus.t1, bus.t0});
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n && bus2.new_t) begin
      if (q2.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL launch2_unexpected: new_t=1 at cycle %0d, expected no launch", cyc);
      end else begin
        cmp_frame("frame2", q2.pop_front(),
                  {bus2.t15, bus2.t14, bus2.t13, bus2.t12, bus2.t11, bus2.t10, bus2.t9, bus2.t8,
                   bus2.t7, bus2.t6, bus2.t5, bus2.t4, bus2.t3, bus2.t2, bus2.t1, bus2.t0});
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic sel, input vec_t v, input int gap,
                            input logic push, input logic chk);
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      if (sel) begin
        bus2.sample_valid = 1'b1;
        bus2.sample_in    = v[i];
      end else begin
        bus.sample_valid = 1'b1;
        bus.sample_in    = v[i];
      end
      step(1);
      bus.sample_valid  = 1'b0;
      bus2.sample_valid = 1'b0;
      if (i < 15) step(gap);
    end
    if (push) begin
      for (int i = 0; i < 16; i++) e.t[i] = model(v[i], !sel);
      e.cyc        = 32'(cyc + 1);
      e.chk_cyc    = chk;
      last_exp_cyc = cyc + 1;
      if (sel) q2.push_back(e);
      else     q1.push_back(e);
    end
  endtask

  task automatic do_reset();
    bus.sample_valid  = 1'b0;
    bus.fft_done      = 1'b0;
    bus2.sample_valid = 1'b0;
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached with %0d checks done", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    vec_t v2;
    int   l1;
    bus.sample_valid  = 1'b0;
    bus.sample_in     = '0;
    bus.fft_done      = 1'b0;
    bus2.sample_valid = 1'b0;
    bus2.sample_in    = '0;
    bus2.fft_done     = 1'b1;
    rst_n = 1'b0;
    step(3);
    check("rst t0", 32'(bus.t0), 32'h0);
    check("rst t15", 32'(bus.t15), 32'h0);
    check("rst new_t", 32'(bus.new_t), 32'h0);
    check("rst busy", 32'(bus.busy), 32'h0);
    check("rst overrun", 32'(bus.overrun), 32'h0);
    rst_n = 1'b1;
    step(1);

    // Offset-binary conversion and launch latency.
    for (int i = 0; i < 16; i++)
      v[i] = (i < 4) ? 12'hFFF : (i < 8) ? 12'h800 : (i < 12) ? 12'h000 : 12'h800;
    send_frame(1'b0, v, 0, 1'b1, 1'b1);
    check("t1 new_t at 16th edge", 32'(bus.new_t), 32'h0);
    step(1);
    check("t1 new_t", 32'(bus.new_t), 32'h1);
    check("t1 busy", 32'(bus.busy), 32'h1);
    check("t1 t0", 32'(bus.t0), 32'h01FF);
    check("t1 t3", 32'(bus.t3), 32'h01FF);
    check("t1 t4", 32'(bus.t4), 32'h0000);
    check("t1 t8", 32'(bus.t8), 32'hFE00);
    check("t1 t11", 32'(bus.t11), 32'hFE00);
    check("t1 t15", 32'(bus.t15), 32'h0000);
    step(1);
    check("t1 new_t one cycle", 32'(bus.new_t), 32'h0);
    step(3);
    check("t1 busy held", 32'(bus.busy), 32'h1);
    bus.fft_done = 1'b1;
    step(1);
    check("t1 busy after done", 32'(bus.busy), 32'h0);
    check("t1 overrun", 32'(bus.overrun), 32'h0);
    bus.fft_done = 1'b0;
    check("t1 queue drained", 32'(q1.size()), 32'h0);

    // Asynchronous reset in the middle of a frame.
    for (int i = 0; i < 9; i++) begin
      bus.sample_valid = 1'b1;
      bus.sample_in    = 12'(12'h100 + i);
      step(1);
      bus.sample_valid = 1'b0;
    end
    #3 rst_n = 1'b0;
    #1;
    check("t2 async t0", 32'(bus.t0), 32'h0);
    check("t2 async t8", 32'(bus.t8), 32'h0);
    check("t2 async new_t", 32'(bus.new_t), 32'h0);
    check("t2 async busy", 32'(bus.busy), 32'h0);
    check("t2 async overrun", 32'(bus.overrun), 32'h0);
    #2 rst_n = 1'b1;
    step(1);
    send_frame(1'b0, gen(1), 0, 1'b1, 1'b1);
    step(1);
    check("t2 fresh launch", 32'(bus.new_t), 32'h1);
    bus.fft_done = 1'b1;
    step(1);
    bus.fft_done = 1'b0;
    step(18);
    check("t2 queue drained", 32'(q1.size()), 32'h0);

    // Back-to-back frames while the FFT is busy.
    do_reset();
    send_frame(1'b0, gen(2), 0, 1'b1, 1'b1);
    l1 = last_exp_cyc;
    send_frame(1'b0, gen(3), 0, 1'b1, 1'b0);
    check("t3 overrun", 32'(bus.overrun), 32'h0);
    check("t3 busy", 32'(bus.busy), 32'h1);
    while (cyc < l1 + 39) step(1);
    bus.fft_done = 1'b1;
    step(1);
    check("t3 idle after done", 32'(bus.busy), 32'h0);
    check("t3 no launch at done edge", 32'(bus.new_t), 32'h0);
    bus.fft_done = 1'b0;
    step(1);
    check("t3 launch after done", 32'(bus.new_t), 32'h1);
    check("t3 busy again", 32'(bus.busy), 32'h1);
    check("t3 overrun after", 32'(bus.overrun), 32'h0);
    bus.fft_done = 1'b1;
    step(1);
    bus.fft_done = 1'b0;
    step(2);
    check("t3 queue drained", 32'(q1.size()), 32'h0);

    // Overrun: third frame dropped, pending frame preserved.
    do_reset();
    send_frame(1'b0, gen(4), 0, 1'b1, 1'b1);
    send_frame(1'b0, gen(5), 0, 1'b1, 1'b0);
    check("t4 overrun before", 32'(bus.overrun), 32'h0);
    send_frame(1'b0, gen(6), 0, 1'b0, 1'b0);
    check("t4 overrun set", 32'(bus.overrun), 32'h1);
    check("t4 busy", 32'(bus.busy), 32'h1);
    step(5);
    bus.fft_done = 1'b1;
    step(1);
    bus.fft_done = 1'b0;
    step(1);
    check("t4 pending launch", 32'(bus.new_t), 32'h1);
    step(2);
    bus.fft_done = 1'b1;
    step(1);
    bus.fft_done = 1'b0;
    step(20);
    check("t4 busy end", 32'(bus.busy), 32'h0);
    check("t4 overrun sticky", 32'(bus.overrun), 32'h1);
    check("t4 queue drained", 32'(q1.size()), 32'h0);

    // fft_done held high: stale done must not cut the launch cycle short.
    do_reset();
    bus.fft_done = 1'b1;
    send_frame(1'b0, gen(7), 0, 1'b1, 1'b1);
    step(1);
    check("t5 new_t", 32'(bus.new_t), 32'h1);
    check("t5 busy launch", 32'(bus.busy), 32'h1);
    step(1);
    check("t5 busy after launch", 32'(bus.busy), 32'h1);
    check("t5 new_t low", 32'(bus.new_t), 32'h0);
    step(1);
    check("t5 idle", 32'(bus.busy), 32'h0);
    send_frame(1'b0, gen(8), 0, 1'b1, 1'b1);
    send_frame(1'b0, gen(9), 0, 1'b1, 1'b1);
    step(4);
    bus.fft_done = 1'b0;
    check("t5 queue drained", 32'(q1.size()), 32'h0);

    // Two's complement input, dense and with 3-cycle sample spacing.
    for (int i = 0; i < 16; i++) v2[i] = 12'(i * 300);
    v2[0] = 12'h7FF;
    v2[1] = 12'h800;
    v2[2] = 12'h004;
    v2[3] = 12'hFFC;
    send_frame(1'b1, v2, 0, 1'b1, 1'b1);
    step(1);
    check("t6 new_t", 32'(bus2.new_t), 32'h1);
    check("t6 t0", 32'(bus2.t0), 32'h01FF);
    check("t6 t1", 32'(bus2.t1), 32'hFE00);
    check("t6 t2", 32'(bus2.t2), 32'h0001);
    check("t6 t3", 32'(bus2.t3), 32'hFFFF);
    step(3);
    send_frame(1'b1, v2, 3, 1'b1, 1'b1);
    step(1);
    check("t6 gap new_t", 32'(bus2.new_t), 32'h1);
    check("t6 gap t0", 32'(bus2.t0), 32'h01FF);
    check("t6 gap t1", 32'(bus2.t1), 32'hFE00);
    check("t6 gap t2", 32'(bus2.t2), 32'h0001);
    check("t6 gap t3", 32'(bus2.t3), 32'hFFFF);
    step(4);
    check("t6 queue drained", 32'(q2.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
